match_report: RTL and testbench

MATCH_REPORT -- requirements
Module: match_report

---
 rtl/match_report.sv | 151 +++++++++++++++
 tb/tb_match_report.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_report.sv
// match_report: turns the string matcher's batch result into a byte stream.
// A report is three header bytes (match flag, position high, position low),
// followed on a match by up to 55 characters pulled one at a time from the
// matcher, which is told to advance after each character has been sent.
module match_report (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rpt_start,
    input  logic [15:0] rpt_str_len,
    input  logic        proc_done,
    input  logic        proc_match,
    input  logic [15:0] proc_byte_pos,
    input  logic [7:0]  proc_match_char,
    output logic        proc_match_char_next,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rpt_busy,
    output logic        rpt_done
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ARM       = 4'd1;
    localparam logic [3:0] S_WAIT_DONE = 4'd2;
    localparam logic [3:0] S_STATUS    = 4'd3;
    localparam logic [3:0] S_POS_HI    = 4'd4;
    localparam logic [3:0] S_POS_LO    = 4'd5;
    localparam logic [3:0] S_CHAR_LOAD = 4'd6;
    localparam logic [3:0] S_CHAR_SEND = 4'd7;
    localparam logic [3:0] S_CHAR_NEXT = 4'd8;

    localparam logic [12:0] MAX_CHARS = 13'd55;

    logic [3:0]  r_state;
    logic [5:0]  r_charCnt;
    logic        r_match;
    logic [15:0] r_pos;
    logic [7:0]  r_txData;
    logic        r_txValid;
    logic        r_charNext;
    logic        r_done;

    logic [12:0] w_lenChars;
    logic [5:0]  w_clampCnt;
    logic        w_xfer;
    logic        w_unusedLenBits;

    // The length arrives in bits; only whole characters count, capped at 55.
    assign w_lenChars      = rpt_str_len[15:3];
    assign w_clampCnt      = (w_lenChars > MAX_CHARS) ? MAX_CHARS[5:0] : w_lenChars[5:0];
    assign w_unusedLenBits = ^rpt_str_len[2:0];

    // A byte moves only when the sink is ready for the byte we hold.
    assign w_xfer = r_txValid & tx_ready;

    assign tx_data              = r_txData;
    assign tx_valid             = r_txValid;
    assign proc_match_char_next = r_charNext;
    assign rpt_done             = r_done;
    assign rpt_busy             = (r_state != S_IDLE);

    // Report sequencer: all outputs are registered so they stay stable under stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_charCnt  <= 6'd0;
            r_match    <= 1'b0;
            r_pos      <= 16'd0;
            r_txData   <= 8'd0;
            r_txValid  <= 1'b0;
            r_charNext <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_charNext <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rpt_start) begin
                        r_charCnt <= w_clampCnt;
                        r_state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (proc_done) begin
                        r_match   <= proc_match;
                        r_pos     <= proc_byte_pos;
                        r_txData  <= {7'b0, proc_match};
                        r_txValid <= 1'b1;
                        r_state   <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    if (w_xfer) begin
                        r_txData <= r_pos[15:8];
                        r_state  <= S_POS_HI;
                    end
                end
                S_POS_HI: begin
                    if (w_xfer) begin
                        r_txData <= r_pos[7:0];
                        r_state  <= S_POS_LO;
                    end
                end
                S_POS_LO: begin
                    if (w_xfer) begin
                        r_txValid <= 1'b0;
                        if (r_match && (r_charCnt != 6'd0)) begin
                            r_state <= S_CHAR_LOAD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_CHAR_LOAD: begin
                    r_txData  <= proc_match_char;
                    r_txValid <= 1'b1;
                    r_state   <= S_CHAR_SEND;
                end
                S_CHAR_SEND: begin
                    if (w_xfer) begin
                        r_txValid  <= 1'b0;
                        r_charNext <= 1'b1;
                        if (r_charCnt != 6'd0) begin
                            r_charCnt <= r_charCnt - 6'd1;
                        end
                        if (r_charCnt <= 6'd1) begin
                            r_done <= 1'b1;
                        end
                        r_state <= S_CHAR_NEXT;
                    end
                end
                S_CHAR_NEXT: begin
                    if (r_charCnt != 6'd0) begin
                        r_state <= S_CHAR_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_txValid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_report.sv
// tb_match_report: drives whole reports into match_report and compares the
// byte stream, advance pulses and done pulses with an expected report built
// directly from the rules (header bytes, then min(len/8, 55) characters).
module tb_match_report;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rpt_start;
    logic [15:0] rpt_str_len;
    logic        proc_done;
    logic        proc_match;
    logic [15:0] proc_byte_pos;
    logic [7:0]  proc_match_char;
    logic        proc_match_char_next;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rpt_busy;
    logic        rpt_done;

    match_report dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .rpt_start            (rpt_start),
        .rpt_str_len          (rpt_str_len),
        .proc_done            (proc_done),
        .proc_match           (proc_match),
        .proc_byte_pos        (proc_byte_pos),
        .proc_match_char      (proc_match_char),
        .proc_match_char_next (proc_match_char_next),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .rpt_busy             (rpt_busy),
        .rpt_done             (rpt_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] matchStr [0:127];
    int         nextPulses = 0;
    int         pulseBase  = 0;

    logic [7:0] byteLog [0:4095];
    int         byteCount = 0;
    int         doneCount = 0;
    int         stallBad  = 0;
    bit         stalled   = 1'b0;
    logic [7:0] stallData = 8'd0;
    bit         randReady = 1'b0;

    // Matcher model: the head character advances once per advance pulse.
    always_comb proc_match_char = matchStr[7'(nextPulses - pulseBase)];

    // Count advance pulses at the edge the matcher would react to.
    always @(posedge clk) begin
        if (proc_match_char_next) nextPulses <= nextPulses + 1;
    end

    // Sink monitor: sampled mid-cycle, logs accepted bytes, done pulses and stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled <= 1'b0;
        end else begin
            if (tx_valid && tx_ready) begin
                byteLog[byteCount[11:0]] <= tx_data;
                byteCount <= byteCount + 1;
            end
            if (stalled && (!tx_valid || tx_data !== stallData)) stallBad <= stallBad + 1;
            stalled   <= tx_valid && !tx_ready;
            stallData <= tx_data;
            if (rpt_done) doneCount <= doneCount + 1;
        end
    end

    // Runaway guard in case a wait loop is ever broken.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tx_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete report: start, optional stale done, result, then drain and compare.
    task automatic applyStimulus(input logic [15:0] len, input bit m, input logic [15:0] pos,
                                 input bit stale, input int lowCycles, input bit abc,
                                 input int resetAt);
        int bBase;
        int dBase;
        int nChars;
        int t;
        bit earlyValid;
        bit aborted;
        logic [7:0] exp [$];

        for (int i = 0; i < 128; i++)
            matchStr[i] = abc ? 8'(8'h61 + (i % 26)) : 8'(8'h61 + $urandom_range(0, 25));
        bBase     = byteCount;
        dBase     = doneCount;
        pulseBase = nextPulses;
        aborted   = 1'b0;

        rpt_start     = 1'b1;
        rpt_str_len   = len;
        proc_done     = stale;
        proc_match    = 1'b0;
        proc_byte_pos = 16'h0000;
        tick();
        checkOutput("busyAfterStart", rpt_busy, 1);
        rpt_start  = 1'b0;
        proc_done  = 1'b0;
        earlyValid = 1'b0;
        for (int i = 0; i < lowCycles; i++) begin
            tick();
            if (tx_valid) earlyValid = 1'b1;
        end
        proc_done     = 1'b1;
        proc_match    = m;
        proc_byte_pos = pos;
        tick();
        checkOutput("noEarlyValid", earlyValid, 0);
        checkOutput("firstValidLatency", tx_valid, 1);

        t = 0;
        while (doneCount == dBase && t < 3000 && !aborted) begin
            tick();
            t++;
            if (resetAt >= 0 && tx_valid && (byteCount - bBase) == resetAt) begin
                reset_n = 1'b0;
                tick();
                checkOutput("abortValid", tx_valid, 0);
                checkOutput("abortBusy", rpt_busy, 0);
                checkOutput("abortNext", proc_match_char_next, 0);
                tick();
                reset_n = 1'b1;
                aborted = 1'b1;
            end
        end
        proc_done = 1'b0;

        if (aborted) begin
            repeat (20) tick();
            checkOutput("abortBytes", byteCount - bBase, resetAt);
            checkOutput("abortDone", doneCount - dBase, 0);
            checkOutput("abortPulses", nextPulses - pulseBase, resetAt - 3);
        end else begin
            checkOutput("doneInTime", (t < 3000), 1);
            repeat (6) tick();
            nChars = m ? int'(len) / 8 : 0;
            if (nChars > 55) nChars = 55;
            exp.push_back({7'b0, m});
            exp.push_back(pos[15:8]);
            exp.push_back(pos[7:0]);
            for (int i = 0; i < nChars; i++) exp.push_back(matchStr[i]);
            checkOutput("byteCount", byteCount - bBase, exp.size());
            for (int i = 0; i < exp.size() && i < (byteCount - bBase); i++)
                checkOutput($sformatf("byte%0d", i), byteLog[bBase + i], exp[i]);
            checkOutput("charPulses", nextPulses - pulseBase, nChars);
            checkOutput("donePulses", doneCount - dBase, 1);
            checkOutput("stallStable", stallBad, 0);
            checkOutput("idleBusy", rpt_busy, 0);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        tx_ready      = 1'b1;
        rpt_start     = 1'b0;
        rpt_str_len   = 16'h0000;
        proc_done     = 1'b0;
        proc_match    = 1'b0;
        proc_byte_pos = 16'h0000;
        for (int i = 0; i < 128; i++) matchStr[i] = 8'h00;

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("rstValid", tx_valid, 0);
        checkOutput("rstData", tx_data, 0);
        checkOutput("rstNext", proc_match_char_next, 0);
        checkOutput("rstBusy", rpt_busy, 0);
        checkOutput("rstDone", rpt_done, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] no match");
        applyStimulus(16'h0040, 1'b0, 16'h0000, 1'b0, 2, 1'b0, -1);

        $display("[TB] match abc");
        applyStimulus(16'h0018, 1'b1, 16'h0123, 1'b0, 3, 1'b1, -1);

        $display("[TB] backpressure and clamp");
        randReady = 1'b1;
        applyStimulus(16'h01F8, 1'b1, 16'($urandom), 1'b0, 2, 1'b0, -1);
        randReady = 1'b0;

        $display("[TB] stale done");
        applyStimulus(16'h0020, 1'b1, 16'hBEEF, 1'b1, 10, 1'b0, -1);

        $display("[TB] reset mid char");
        applyStimulus(16'h0028, 1'b1, 16'h0456, 1'b0, 2, 1'b1, 4);
        applyStimulus(16'h0018, 1'b1, 16'h0123, 1'b0, 2, 1'b1, -1);

        $display("[TB] random reports");
        for (int k = 0; k < 8; k++) begin
            randReady = 1'($urandom_range(0, 1));
            applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 1)), $urandom_range(1, 5), 1'b0, -1);
        end
        randReady = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
